// File: rtl/mem_access_ctrl_if.sv
// Word-wide memory bus between the load/store controller (master) and memory (slave).
// A transaction is held by bus_req until the cycle the slave returns bus_ack.
`ifndef MEM_MODE_WORD
`define MEM_MODE_WORD       3'd0
`define MEM_MODE_HWORD      3'd1
`define MEM_MODE_HWORD_SIGN 3'd2
`define MEM_MODE_BYTE       3'd3
`define MEM_MODE_BYTE_SIGN  3'd4
`endif

interface mem_access_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store unit: turns core byte/halfword/word accesses into word bus transactions (RMW for sub-word stores).
// Latency: 2 cycles for loads/word stores, 4 for sub-word stores, plus bus wait cycles; faults complete in 1.
// Backpressure: busy stalls the core outside IDLE; bus states hold until bus_ack.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  mem_acc_mode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    mem_access_ctrl_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, MERGE, RMW_WR, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] lat_addr, lat_wdata, word_buf;
    logic [2:0]  lat_mode;
    logic        fault;
    logic        accept;
    logic        req_half, req_byte, req_misaligned;
    logic        lat_byte;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, merged;

    // Unknown mode codes behave as word accesses.
    always_comb begin
        req_half = (mem_acc_mode == `MEM_MODE_HWORD) || (mem_acc_mode == `MEM_MODE_HWORD_SIGN);
        req_byte = (mem_acc_mode == `MEM_MODE_BYTE) || (mem_acc_mode == `MEM_MODE_BYTE_SIGN);
        req_misaligned = req_half ? addr[0] : (!req_byte && (addr[1:0] != 2'b00));
        lat_byte = (lat_mode == `MEM_MODE_BYTE) || (lat_mode == `MEM_MODE_BYTE_SIGN);
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start && (mem_read || mem_write)) begin
                    accept = 1'b1;
                    if (req_misaligned)
                        state_nxt = DONE;
                    else if (mem_read)
                        state_nxt = RD;
                    else if (req_half || req_byte)
                        state_nxt = RMW_RD;
                    else
                        state_nxt = WR;
                end
            end
            RD, WR:  if (bus.bus_ack) state_nxt = DONE;
            RMW_RD:  if (bus.bus_ack) state_nxt = MERGE;
            MERGE:   state_nxt = RMW_WR;
            RMW_WR:  if (bus.bus_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_wdata = 32'h0;
        busy          = (state != IDLE);
        done          = (state == DONE);
        misaligned    = (state == DONE) && fault;
        case (state)
            RD, RMW_RD: begin
                bus.bus_req  = 1'b1;
                bus.bus_addr = {lat_addr[31:2], 2'b00};
            end
            WR: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = {lat_addr[31:2], 2'b00};
                bus.bus_wdata = lat_wdata;
            end
            RMW_WR: begin
                bus.bus_req   = 1'b1;
                bus.bus_we    = 1'b1;
                bus.bus_addr  = {lat_addr[31:2], 2'b00};
                bus.bus_wdata = word_buf;
            end
            default: ;
        endcase
    end

    // Lane extraction for loads and lane replacement for the read-modify-write merge.
    always_comb begin
        byte_sh  = {lat_addr[1:0], 3'b000};
        half_sh  = {lat_addr[1], 4'b0000};
        byte_sel = bus.bus_rdata[byte_sh +: 8];
        half_sel = bus.bus_rdata[half_sh +: 16];
        case (lat_mode)
            `MEM_MODE_BYTE:       load_val = {24'h0, byte_sel};
            `MEM_MODE_BYTE_SIGN:  load_val = {{24{byte_sel[7]}}, byte_sel};
            `MEM_MODE_HWORD:      load_val = {16'h0, half_sel};
            `MEM_MODE_HWORD_SIGN: load_val = {{16{half_sel[15]}}, half_sel};
            default:              load_val = bus.bus_rdata;
        endcase
        merged = word_buf;
        if (lat_byte)
            merged[byte_sh +: 8] = lat_wdata[7:0];
        else
            merged[half_sh +: 16] = lat_wdata[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr  <= 32'h0;
            lat_wdata <= 32'h0;
            lat_mode  <= 3'h0;
            fault     <= 1'b0;
            word_buf  <= 32'h0;
            rdata     <= 32'h0;
        end else begin
            if (accept) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_mode  <= mem_acc_mode;
                fault     <= req_misaligned;
                if (req_misaligned)
                    rdata <= 32'h0;
            end
            if (state == RD && bus.bus_ack)
                rdata <= load_val;
            if (state == RMW_RD && bus.bus_ack)
                word_buf <= bus.bus_rdata;
            if (state == MERGE)
                word_buf <= merged;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboarded bench for mem_access_ctrl: a memory model answers the bus with programmable wait states.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_acc_mode = 3'd0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, misaligned;
    logic [31:0] rdata;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_acc_mode (mem_acc_mode),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .rdata        (rdata),
        .misaligned   (misaligned),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          cyc;
    } done_exp_t;

    bus_exp_t    bus_q[$];
    done_exp_t   done_q[$];
    logic [31:0] mem [logic [31:0]];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          wait_n = 0;
    logic [31:0] model_rdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] exp_load(input logic [2:0] mode, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (mode)
            `MEM_MODE_BYTE:       return b;
            `MEM_MODE_BYTE_SIGN:  return (b > 32'h7F) ? (b | 32'hFFFFFF00) : b;
            `MEM_MODE_HWORD:      return h;
            `MEM_MODE_HWORD_SIGN: return (h > 32'h7FFF) ? (h | 32'hFFFF0000) : h;
            default:              return w;
        endcase
    endfunction

    function automatic logic [31:0] exp_merge(input logic [2:0] mode, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
        int sh;
        logic [31:0] m;
        if (mode == `MEM_MODE_BYTE || mode == `MEM_MODE_BYTE_SIGN) begin
            sh = 8 * int'(a[1:0]);
            m  = 32'hFF << sh;
            return (w & ~m) | ((d & 32'hFF) << sh);
        end
        sh = 16 * int'(a[1]);
        m  = 32'hFFFF << sh;
        return (w & ~m) | ((d & 32'hFFFF) << sh);
    endfunction

    function automatic logic exp_mis(input logic [2:0] mode, input logic [31:0] a);
        if (mode == `MEM_MODE_WORD)
            return (a % 4) != 0;
        if (mode == `MEM_MODE_HWORD || mode == `MEM_MODE_HWORD_SIGN)
            return (a % 2) != 0;
        return 1'b0;
    endfunction

    // Memory slave: acks after wait_n cycles of bus_req and checks each transaction against the scoreboard.
    initial begin
        int w_cnt;
        bus_exp_t e;
        w_cnt = 0;
        bus.bus_ack = 1'b0;
        bus.bus_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.bus_req !== 1'b1) begin
                bus.bus_ack = 1'b0;
                w_cnt = 0;
            end else if (w_cnt < wait_n) begin
                bus.bus_ack = 1'b0;
                bus.bus_rdata = $urandom;
                w_cnt++;
            end else begin
                bus.bus_ack = 1'b1;
                bus.bus_rdata = mem.exists(bus.bus_addr) ? mem[bus.bus_addr] : 32'h0;
                w_cnt = 0;
                n_checks++;
                if (bus_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_unexpected: we=%b addr=%h wdata=%h, required no transaction",
                             bus.bus_we, bus.bus_addr, bus.bus_wdata);
                end else begin
                    e = bus_q.pop_front();
                    if (bus.bus_we !== e.we || bus.bus_addr !== e.addr ||
                        (e.we && bus.bus_wdata !== e.data)) begin
                        n_fail++;
                        $display("FAIL bus_txn: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 bus.bus_we, bus.bus_addr, bus.bus_wdata, e.we, e.addr, e.data);
                    end
                end
                if (bus.bus_we === 1'b1)
                    mem[bus.bus_addr] = bus.bus_wdata;
            end
        end
    end

    // Completion monitor.
    always @(negedge clk) begin
        done_exp_t d;
        if (done === 1'b1) begin
            n_checks++;
            if (done_q.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: done=1 at cycle %0d, required no completion", cyc);
            end else begin
                d = done_q.pop_front();
                if (rdata !== d.rdata || misaligned !== d.mis || cyc != d.cyc) begin
                    n_fail++;
                    $display("FAIL done_result: rdata=%h mis=%b cycle=%0d, required rdata=%h mis=%b cycle=%0d",
                             rdata, misaligned, cyc, d.rdata, d.mis, d.cyc);
                end
            end
        end else begin
            n_checks++;
            if (misaligned !== 1'b0) begin
                n_fail++;
                $display("FAIL mis_without_done: misaligned=%b, required 0", misaligned);
            end
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [2:0] mode,
                         input logic [31:0] a, input logic [31:0] wd, input int waits);
        int g;
        logic [31:0] wa, w;
        g = 0;
        @(posedge clk);
        #1;
        while (busy !== 1'b0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_idle: busy=%b, required 0", busy);
        end
        wait_n = waits;
        wa = {a[31:2], 2'b00};
        w  = mem.exists(wa) ? mem[wa] : 32'h0;
        if (rd || wr) begin
            if (exp_mis(mode, a)) begin
                model_rdata = 32'h0;
                done_q.push_back('{rdata: 32'h0, mis: 1'b1, cyc: cyc + 1});
            end else if (rd) begin
                model_rdata = exp_load(mode, a, w);
                bus_q.push_back('{we: 1'b0, addr: wa, data: 32'h0});
                done_q.push_back('{rdata: model_rdata, mis: 1'b0, cyc: cyc + 2 + waits});
            end else if (mode == `MEM_MODE_WORD) begin
                bus_q.push_back('{we: 1'b1, addr: wa, data: wd});
                done_q.push_back('{rdata: model_rdata, mis: 1'b0, cyc: cyc + 2 + waits});
            end else begin
                bus_q.push_back('{we: 1'b0, addr: wa, data: 32'h0});
                bus_q.push_back('{we: 1'b1, addr: wa, data: exp_merge(mode, a, w, wd)});
                done_q.push_back('{rdata: model_rdata, mis: 1'b0, cyc: cyc + 4 + 2 * waits});
            end
        end
        start = 1'b1;
        mem_read = rd;
        mem_write = wr;
        mem_acc_mode = mode;
        addr = a;
        wdata = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
        mem_read = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        mem_acc_mode = 3'($urandom_range(0, 4));
        addr = $urandom;
        wdata = $urandom;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy !== 1'b0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, g);
        end
        n_checks++;
        if (done_q.size() != 0 || bus_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending: done_q=%0d bus_q=%0d outstanding, required 0 0", done_q.size(), bus_q.size());
            done_q.delete();
            bus_q.delete();
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, misaligned, bus.bus_req, bus.bus_we} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy,done,mis,req,we=%b, required 00000",
                     {busy, done, misaligned, bus.bus_req, bus.bus_we});
        end
        n_checks++;
        if (bus.bus_addr !== 32'h0 || bus.bus_wdata !== 32'h0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, required 0 0 0",
                     bus.bus_addr, bus.bus_wdata, rdata);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        mem[32'h100] = 32'hDEADBEEF;
        issue(1'b1, 1'b0, `MEM_MODE_WORD, 32'h100, 32'h0, 0);
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b0 || bus.bus_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL lw_bus: req=%b we=%b addr=%h, required 1 0 00000100",
                     bus.bus_req, bus.bus_we, bus.bus_addr);
        end
        wait_idle();
        n_checks++;
        if (rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL lw_rdata: rdata=%h, required deadbeef", rdata);
        end
        // Both control bits set: the read wins.
        issue(1'b1, 1'b1, `MEM_MODE_WORD, 32'h100, 32'h55555555, 1);
        wait_idle();
    endtask

    task automatic test_sub_loads();
        logic [2:0]  md [6] = '{`MEM_MODE_BYTE_SIGN, `MEM_MODE_BYTE, `MEM_MODE_HWORD_SIGN,
                                `MEM_MODE_HWORD, `MEM_MODE_BYTE_SIGN, `MEM_MODE_BYTE};
        logic [31:0] ad [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100};
        logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AA,
                                32'h0000BBCC, 32'hFFFFFFBB, 32'h000000CC};
        mem[32'h100] = 32'h80AABBCC;
        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 1'b0, md[i], ad[i], 32'h0, i % 2);
            wait_idle();
            n_checks++;
            if (rdata !== ex[i]) begin
                n_fail++;
                $display("FAIL subload_%0d: rdata=%h, required %h", i, rdata, ex[i]);
            end
        end
    endtask

    task automatic test_sub_store();
        mem[32'h100] = 32'h11223344;
        issue(1'b0, 1'b1, `MEM_MODE_BYTE, 32'h102, 32'h123456AB, 0);
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b0 || bus.bus_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL sb_rmw_rd: req=%b we=%b addr=%h, required 1 0 00000100",
                     bus.bus_req, bus.bus_we, bus.bus_addr);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (bus.bus_req !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_merge: req=%b busy=%b, required 0 1", bus.bus_req, busy);
        end
        @(posedge clk);
        #2;
        n_checks++;
        if (bus.bus_req !== 1'b1 || bus.bus_we !== 1'b1 || bus.bus_wdata !== 32'h11AB3344) begin
            n_fail++;
            $display("FAIL sb_rmw_wr: req=%b we=%b wdata=%h, required 1 1 11ab3344",
                     bus.bus_req, bus.bus_we, bus.bus_wdata);
        end
        wait_idle();
        n_checks++;
        if (mem[32'h100] !== 32'h11AB3344) begin
            n_fail++;
            $display("FAIL sb_mem: word=%h, required 11ab3344", mem[32'h100]);
        end
        issue(1'b0, 1'b1, `MEM_MODE_HWORD, 32'h102, 32'h9999BEEF, 1);
        wait_idle();
        n_checks++;
        if (mem[32'h100] !== 32'hBEEF3344) begin
            n_fail++;
            $display("FAIL sh_mem: word=%h, required beef3344", mem[32'h100]);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] ad [2] = '{32'h101, 32'h106};
        for (int i = 0; i < 2; i++) begin
            issue(1'b1, 1'b0, `MEM_MODE_WORD, 32'h100, 32'h0, 0);
            wait_idle();
            if (i == 0)
                issue(1'b1, 1'b0, `MEM_MODE_HWORD, ad[i], 32'h0, 0);
            else
                issue(1'b0, 1'b1, `MEM_MODE_WORD, ad[i], 32'h12345678, 0);
            n_checks++;
            if (done !== 1'b1 || misaligned !== 1'b1 || bus.bus_req !== 1'b0 || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL misaligned_%0d: done=%b mis=%b req=%b rdata=%h, required 1 1 0 00000000",
                         i, done, misaligned, bus.bus_req, rdata);
            end
            wait_idle();
        end
    endtask

    task automatic test_ignored();
        issue(1'b0, 1'b0, `MEM_MODE_WORD, 32'h100, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL ignored_%0d: busy=%b done=%b, required 0 0", i, busy, done);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        mem[32'h300] = 32'h5555AAAA;
        issue(1'b1, 1'b0, `MEM_MODE_WORD, 32'h300, 32'h0, 3);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            bus.bus_addr !== 32'h0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b busy=%b done=%b addr=%h rdata=%h, required 0 0 0 0 0",
                     bus.bus_req, busy, done, bus.bus_addr, rdata);
        end
        // The abandoned load produces neither a bus ack nor a completion.
        bus_q.delete();
        done_q.delete();
        model_rdata = 32'h0;
        #3 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (busy !== 1'b0 || bus.bus_req !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_%0d: busy=%b req=%b, required 0 0", i, busy, bus.bus_req);
            end
        end
        issue(1'b1, 1'b0, `MEM_MODE_WORD, 32'h300, 32'h0, 1);
        wait_idle();
        n_checks++;
        if (rdata !== 32'h5555AAAA) begin
            n_fail++;
            $display("FAIL reload_rdata: rdata=%h, required 5555aaaa", rdata);
        end
    endtask

    task automatic test_store_wait();
        mem[32'h200] = 32'h0;
        issue(1'b0, 1'b1, `MEM_MODE_WORD, 32'h200, 32'hCAFEF00D, 2);
        // A second request while busy must be ignored.
        start = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b1;
        mem_acc_mode = `MEM_MODE_WORD;
        addr = 32'h204;
        wdata = 32'h0BADBEEF;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sw_busy_%0d: busy=%b, required 1", i, busy);
            end
            if (i == 1)
                start = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_idle();
        n_checks++;
        if (mem[32'h200] !== 32'hCAFEF00D || mem.exists(32'h204)) begin
            n_fail++;
            $display("FAIL sw_mem: word=%h stray_write=%b, required cafef00d 0",
                     mem[32'h200], mem.exists(32'h204));
        end
    endtask

    task automatic test_random();
        logic [2:0]  modes [5] = '{`MEM_MODE_WORD, `MEM_MODE_HWORD, `MEM_MODE_HWORD_SIGN,
                                   `MEM_MODE_BYTE, `MEM_MODE_BYTE_SIGN};
        logic        rd, wr;
        for (int i = 0; i < 4; i++)
            mem[32'h400 + 32'(4 * i)] = $urandom;
        for (int i = 0; i < 30; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = !rd || ($urandom_range(0, 1) == 1);
            issue(rd, wr, modes[$urandom_range(0, 4)], 32'h400 + 32'($urandom_range(0, 15)),
                  $urandom, $urandom_range(0, 2));
            wait_idle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_load();
        test_sub_loads();
        test_sub_store();
        test_misaligned();
        test_ignored();
        test_reset_mid();
        test_store_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: none; byte order is fixed little-endian (byte lane n = bits 8n+7:8n).
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  core requests a load/store this cycle; sampled only in IDLE.
REQ-005 mem_read / mem_write  in  1 each  decoder control bits.
REQ-006 mem_acc_mode  in  3  decoder access mode: `MEM_MODE_WORD, _HWORD, _HWORD_SIGN, _BYTE, _BYTE_SIGN from define.v.
REQ-007 addr  in  32  byte address (ALU result); wdata  in  32  store data (rt).
REQ-008 busy  out  1  stall to core; done  out  1  one-cycle completion pulse.
REQ-009 rdata  out  32  extended load result; misaligned  out  1  alignment fault, valid with done.
REQ-010 bus_req / bus_we  out  1 each; bus_addr  out  32 (word-aligned); bus_wdata  out  32.
REQ-011 bus_rdata  in  32; bus_ack  in  1  completes current bus transaction.

Function
REQ-012 States SHALL be IDLE, RD, WR, RMW_RD, MERGE, RMW_WR, DONE.
REQ-013 IDLE + start + mem_read SHALL latch addr, wdata, mode and go RD; mem_read has priority if both read and write are set.
REQ-014 IDLE + start + mem_write (no mem_read) SHALL go WR for WORD mode, RMW_RD for BYTE/HWORD modes.
REQ-015 IDLE + start with neither bit set SHALL be ignored (stay IDLE, no done).
REQ-016 Misaligned access (WORD with addr[1:0]!=0; HWORD/HWORD_SIGN with addr[0]!=0) SHALL go directly to DONE with misaligned=1, rdata=0, no bus_req.
REQ-017 bus_req SHALL be 1 exactly in RD, WR, RMW_RD, RMW_WR; bus_we=1 in WR and RMW_WR only.
REQ-018 bus_addr SHALL be {latched_addr[31:2],2'b00} whenever bus_req=1.
REQ-019 Bus states SHALL hold with bus_req, bus_addr, bus_wdata stable until a cycle with bus_ack=1; bus_ack while bus_req=0 SHALL be ignored.
REQ-020 RD on ack: capture lane per mode; BYTE zero-extend, BYTE_SIGN sign-extend lane addr[1:0]; HWORD zero-/HWORD_SIGN sign-extend bits 15:0 (addr[1]=0) or 31:16 (addr[1]=1); WORD unchanged; then DONE.
REQ-021 RMW_RD on ack: store read word, go MERGE (bus_req=0, one cycle), replacing the addressed byte with wdata[7:0] or halfword with wdata[15:0], then RMW_WR.
REQ-022 WR bus_wdata SHALL be latched wdata; RMW_WR bus_wdata SHALL be merged word; on ack go DONE.
REQ-023 DONE SHALL assert done=1 for exactly one cycle, then IDLE; misaligned valid only while done=1.
REQ-024 busy SHALL be 1 in every state except IDLE; start outside IDLE SHALL be ignored.
REQ-025 rdata SHALL hold its value until the next completed load or misaligned fault; stores leave it unchanged.
REQ-026 Latency with zero-wait bus (ack in first req cycle): load/word store done 2 cycles after start; sub-word store done 4 cycles after start.
REQ-027 Input changes after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, busy=0, done=0, misaligned=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, rdata=0, regardless of clock.
REQ-029 Reset during any bus state SHALL abandon the transaction with no done pulse; first start after rst deasserts is accepted normally.

Verification
REQ-030 lw addr 0x100, bus_rdata 0xDEADBEEF, ack immediate -> bus_addr 0x100, bus_we 0, done at start+2, rdata 0xDEADBEEF.
REQ-031 lb addr 0x103, bus_rdata 0x80AABBCC -> rdata 0xFFFFFF80; lbu same -> 0x00000080; lh addr 0x102 -> 0xFFFF80AA.
REQ-032 sb addr 0x102, wdata 0x123456AB, memory word 0x11223344 -> RMW read 0x100, one bus_req-low cycle, write 0x11AB3344 to 0x100, done at start+4.
REQ-033 lh addr 0x101 and sw addr 0x106 -> no bus_req, done next cycle with misaligned=1, rdata 0.
REQ-034 lw with ack delayed 3 cycles, rst pulsed in second RD cycle -> bus_req drops asynchronously, busy 0, no done; following lw completes normally.
REQ-035 sw addr 0x200 wdata 0xCAFEF00D with 2 wait cycles, addr/wdata changed after start -> single write 0xCAFEF00D to 0x200, busy held until done.
